// File: rtl/calc_key_sequencer.sv
// Push-button front end for the calculator control unit: synchronise, debounce, edge-detect,
// then sequence startX/startY/startS requests. Define CALC_KEY_DEBOUNCE_EN to build in the debouncers.
module calc_key_sequencer #(
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter logic [15:0] ACK_TIMEOUT = 16'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic [3:0] btn_op,
  input  logic       btn_clr,
  input  logic       ldX,
  input  logic       ldY,
  input  logic       done,
  output logic       startX,
  output logic       startY,
  output logic       startS,
  output logic [1:0] sel,
  output logic       cu_clr,
  output logic [1:0] phase,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    X_WAIT, X_REQ, Y_WAIT, Y_REQ, OP_WAIT, OP_REQ, RESULT
  } state_t;

  // Bit 0 = enter, bits 4:1 = op keys, bit 5 = clear.
  logic [5:0] sync1_q, sync2_q, lvl, lvl_q, ev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_clr, btn_op, btn_enter};
      sync2_q <= sync1_q;
    end
  end

`ifdef CALC_KEY_DEBOUNCE_EN
  logic [5:0]  deb_q;
  logic [15:0] cnt_q [6];

  // A new level is accepted once it has differed from the held level for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (({1'b0, cnt_q[i]} + 17'd1) >= {1'b0, DEB_CYCLES}) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q <= '0;
      ev_q  <= '0;
    end else begin
      lvl_q <= lvl;
      ev_q  <= lvl & ~lvl_q;
    end
  end

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        err_q, err_d;
  logic        clr_q, clr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        enter_ev, clr_ev, ack, tmo_hit;
  logic [3:0]  op_ev;

  assign enter_ev = ev_q[0];
  assign op_ev    = ev_q[4:1];
  assign clr_ev   = ev_q[5];
  assign ack      = (state_q == X_REQ && ldX) || (state_q == Y_REQ && ldY) ||
                    (state_q == OP_REQ && done);
  // Terminal count: this is the ACK_TIMEOUT-th cycle the request has been waiting.
  assign tmo_hit  = ({1'b0, tmo_q} + 17'd1) >= {1'b0, ACK_TIMEOUT};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= X_WAIT;
      sel_q   <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    clr_d   = 1'b0;
    if (clr_ev) begin
      state_d = X_WAIT;
      clr_d   = 1'b1;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        X_WAIT:  if (enter_ev) state_d = X_REQ;
        Y_WAIT:  if (enter_ev) state_d = Y_REQ;
        RESULT:  if (enter_ev) state_d = X_REQ;
        OP_WAIT: begin
          if (op_ev != '0) begin
            state_d = OP_REQ;
            if (op_ev[0])      sel_d = 2'd0;
            else if (op_ev[1]) sel_d = 2'd1;
            else if (op_ev[2]) sel_d = 2'd2;
            else               sel_d = 2'd3;
          end
        end
        X_REQ, Y_REQ, OP_REQ: begin
          if (ack) begin
            if (state_q == X_REQ)      state_d = Y_WAIT;
            else if (state_q == Y_REQ) state_d = OP_WAIT;
            else                       state_d = RESULT;
          end else if (tmo_hit) begin
            state_d = X_WAIT;
            err_d   = 1'b1;
            clr_d   = 1'b1;
          end
        end
        default: state_d = X_WAIT;
      endcase
    end
    tmo_d = '0;
    if (busy && state_d == state_q) tmo_d = tmo_q + 16'd1;
  end

  always_comb begin
    phase = 2'd0;
    unique case (state_q)
      Y_WAIT, Y_REQ:   phase = 2'd1;
      OP_WAIT, OP_REQ: phase = 2'd2;
      RESULT:          phase = 2'd3;
      default:         phase = 2'd0;
    endcase
  end

  assign startX = (state_q == X_REQ);
  assign startY = (state_q == Y_REQ);
  assign startS = (state_q == OP_REQ);
  assign busy   = startX | startY | startS;
  assign sel    = sel_q;
  assign cu_clr = clr_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Randomised scoreboard bench for calc_key_sequencer: stimulus queues expected request/clear
// observations, a negedge monitor pops them as requests release and cu_clr pulses appear.
module tb_calc_key_sequencer;

  localparam logic [15:0] DEB = 16'd4;
  localparam logic [15:0] TMO = 16'd255;
`ifdef CALC_KEY_DEBOUNCE_EN
  localparam int LAT = 3 + int'(DEB);
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0, rst = 1'b0;
  logic       btn_enter = 1'b0, btn_clr = 1'b0, ldX = 1'b0, ldY = 1'b0, done = 1'b0;
  logic [3:0] btn_op = '0;
  logic       startX, startY, startS, cu_clr, busy, err;
  logic [1:0] sel, phase;
  logic [2:0] st;

  calc_key_sequencer #(.DEB_CYCLES(DEB), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .btn_enter(btn_enter), .btn_op(btn_op), .btn_clr(btn_clr),
    .ldX(ldX), .ldY(ldY), .done(done), .startX(startX), .startY(startY), .startS(startS),
    .sel(sel), .cu_clr(cu_clr), .phase(phase), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  assign st = {startS, startY, startX};

  // kind: 0/1/2 = X/Y/S request, 3 = cu_clr pulse; lat/len of 0 are not checked.
  typedef struct {
    int kind; int lat; int len; int ph_in; int ph_out; int sel; int err;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, press_cyc = 0;

  function automatic void chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push_exp(input int k, input int lat, input int len, input int ph_in,
                                   input int ph_out, input int s, input int e);
    obs_t o;
    o = '{k, lat, len, ph_in, ph_out, s, e};
    exp_q.push_back(o);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] prv = '0;
  logic [2:0] cur;
  int         rlat[3], rlen[3], rph[3];
  int         rsel;
  obs_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      prv = '0;
    end else begin
      cur = st;
      chk("start_onehot", int'($countones(cur) <= 1), 1);
      chk("busy", int'(busy), int'(|cur));
      for (int k = 0; k < 3; k++) begin
        if (cur[k] && !prv[k]) begin
          rlat[k] = cyc - press_cyc;
          rlen[k] = 1;
          rph[k]  = int'(phase);
          if (k == 2) rsel = int'(sel);
        end else if (cur[k]) begin
          rlen[k]++;
          if (k == 2) chk("sel_hold", int'(sel), rsel);
        end else if (prv[k]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_release", k, -1);
          end else begin
            e = exp_q.pop_front();
            chk("kind", k, e.kind);
            if (e.lat > 0) chk("event_latency", rlat[k], e.lat);
            if (e.len > 0) chk("req_length", rlen[k], e.len);
            chk("phase_in_req", rph[k], e.ph_in);
            chk("phase_after", int'(phase), e.ph_out);
            if (k == 2) begin
              chk("sel_in_req", rsel, e.sel);
              chk("sel_after", int'(sel), e.sel);
            end
          end
        end
      end
      if (cu_clr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cu_clr", 3, -1);
        end else begin
          e = exp_q.pop_front();
          chk("kind", 3, e.kind);
          chk("err_at_clr", int'(err), e.err);
          chk("phase_at_clr", int'(phase), 0);
        end
      end
      prv = cur;
    end
  end

  task automatic settle();
    repeat (LAT + 3) @(negedge clk);
  endtask

  // Press the key for request k, wait for the request, then ack after d cycles (or let it time out).
  task automatic req_cycle(input int k, input logic [3:0] opv, input int d, input bit ack_it);
    bit seen;
    int s;
    press_cyc = cyc;
    if (k == 2) btn_op = opv;
    else        btn_enter = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LAT + 10 && !seen; i++) begin
      @(negedge clk);
      seen = st[k];
    end
    chk("request_raised", int'(seen), 1);
    btn_enter = 1'b0;
    btn_op    = '0;
    s = 0;
    for (int i = 3; i >= 0; i--) if (opv[i]) s = i;
    push_exp(k, LAT + 1, ack_it ? d + 1 : int'(TMO), k, ack_it ? k + 1 : 0, s, 0);
    if (!ack_it) push_exp(3, 0, 0, 0, 0, 0, 1);
    if (ack_it) begin
      repeat (d) @(negedge clk);
      if (k == 0) ldX = 1'b1;
      else if (k == 1) ldY = 1'b1;
      else done = 1'b1;
      @(negedge clk);
      ldX = 1'b0; ldY = 1'b0; done = 1'b0;
    end else begin
      repeat (int'(TMO) + 2) @(negedge clk);
    end
    settle();
  endtask

  task automatic press_clr(input bit with_enter);
    push_exp(3, 0, 0, 0, 0, 0, 0);
    btn_clr = 1'b1;
    btn_enter = with_enter;
    repeat (LAT + 2) @(negedge clk);
    btn_clr = 1'b0;
    btn_enter = 1'b0;
    settle();
  endtask

  task automatic stray(input bit enter, input logic [3:0] opv);
    btn_enter = enter;
    btn_op = opv;
    repeat (LAT + 2) @(negedge clk);
    btn_enter = 1'b0;
    btn_op = '0;
    settle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_startX", int'(startX), 0);
    chk("rst_startY", int'(startY), 0);
    chk("rst_startS", int'(startS), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_cu_clr", int'(cu_clr), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    settle();

    // Directed full sequence, then lowest-set-bit op priority.
    req_cycle(0, 4'b0000, 2, 1'b1);
    req_cycle(1, 4'b0000, 2, 1'b1);
    req_cycle(2, 4'b0100, 2, 1'b1);
    req_cycle(0, 4'b0000, 0, 1'b1);
    req_cycle(1, 4'b0000, 1, 1'b1);
    req_cycle(2, 4'b1010, 3, 1'b1);

    // Random transactions with ignored keys/acks sprinkled in; one ack lands on the terminal count.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) stray(1'b0, 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 1) == 1) begin
        ldY = 1'b1; done = 1'b1;
        @(negedge clk);
        ldY = 1'b0; done = 1'b0;
      end
      req_cycle(0, 4'b0000, (t == 3) ? int'(TMO) - 1 : int'($urandom_range(0, 4)), 1'b1);
      req_cycle(1, 4'b0000, int'($urandom_range(0, 4)), 1'b1);
      if ($urandom_range(0, 1) == 1) stray(1'b1, 4'b0000);
      req_cycle(2, 4'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'b1);
    end

    // Timeout in Y_REQ, then a clear drops err.
    req_cycle(0, 4'b0000, 1, 1'b1);
    req_cycle(1, 4'b0000, 0, 1'b0);
    press_clr(1'b0);

    // Clear and enter together in X_WAIT: only the clear acts.
    press_clr(1'b1);

    // Bouncing enter yields a single X request.
`ifndef CALC_KEY_DEBOUNCE_EN
    press_cyc = cyc;
`endif
    for (int i = 0; i < 10; i++) begin
      btn_enter = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
`ifdef CALC_KEY_DEBOUNCE_EN
    press_cyc = cyc;
`endif
    btn_enter = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    push_exp(0, LAT + 1, 0, 0, 1, 0, 0);
    ldX = 1'b1;
    @(negedge clk);
    ldX = 1'b0;
    btn_enter = 1'b0;
    settle();
    press_clr(1'b0);

    // Asynchronous reset in OP_REQ.
    req_cycle(0, 4'b0000, 1, 1'b1);
    req_cycle(1, 4'b0000, 1, 1'b1);
    btn_op = 4'b0010;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LAT + 10 && !seen; i++) begin
        @(negedge clk);
        seen = startS;
      end
      chk("opreq_before_reset", int'(seen), 1);
    end
    btn_op = '0;
    chk("sel_before_reset", int'(sel), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_startS", int'(startS), 0);
    chk("async_rst_sel", int'(sel), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_phase", int'(phase), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    settle();
    req_cycle(0, 4'b0000, 2, 1'b1);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Front-end command sequencer for the digital calculator. It turns raw push-button inputs (enter, four operation keys, clear) into the `startX` / `startY` / `startS` / `sel` request handshake consumed by the calculator control unit. It holds each request until the control unit acknowledges it with `ldX`, `ldY` or `done`. It also drives a clear pulse for the control unit and a phase indicator for the display mux.

## Interface
- `DEB_CYCLES`, 16'd50000: stable cycles required before a synchronized button level is accepted.
- `ACK_TIMEOUT`, 16'd255: maximum cycles a request may wait for its acknowledge.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low. Asserted when 0.
- `btn_enter` in 1: raw enter button, active-high, asynchronous.
- `btn_op` in 4: raw operation buttons, one bit per ALU op.
- `btn_clr` in 1: raw clear button.
- `ldX` in 1: acknowledge for `startX`, from the control unit.
- `ldY` in 1: acknowledge for `startY`.
- `done` in 1: acknowledge for `startS`.
- `startX` out 1: load-X request.
- `startY` out 1: load-Y request.
- `startS` out 1: execute request.
- `sel` out 2: op select. Valid and stable while `startS`=1.
- `cu_clr` out 1: one-cycle clear pulse to the control unit.
- `phase` out 2: display phase. 0 = entering X, 1 = entering Y, 2 = selecting op, 3 = result shown.
- `busy` out 1: high while any request is outstanding.
- `err` out 1: sticky acknowledge-timeout flag.

## Operation
- Every button passes through a 2-flop synchronizer and then the debouncer. A press event is a single-cycle pulse on the rising edge of the debounced level.
- States: X_WAIT, X_REQ, Y_WAIT, Y_REQ, OP_WAIT, OP_REQ, RESULT.
- X_WAIT: on enter, go to X_REQ. `phase`=0.
- X_REQ: `startX`=1. On sampled `ldX`=1, go to Y_WAIT. `phase` stays 0.
- Y_WAIT: on enter, go to Y_REQ. `phase`=1.
- Y_REQ: `startY`=1. On `ldY`=1, go to OP_WAIT. `phase` stays 1.
- OP_WAIT: on any op event, latch `sel` and go to OP_REQ. `sel` = index of the lowest set bit of the op event vector. `phase`=2.
- OP_REQ: `startS`=1. On `done`=1, go to RESULT. `phase` stays 2.
- RESULT: `phase`=3. On enter, go to X_REQ (new X entry). `phase` becomes 0.
- At most one `start*` output is high at any time. `busy` = X_REQ | Y_REQ | OP_REQ.
- Clear event in any state:
  - go to X_WAIT;
  - drop all requests;
  - pulse `cu_clr` for 1 cycle;
  - clear `err`.
- Timeout: a counter resets on entry to any REQ state. If it reaches `ACK_TIMEOUT` without the acknowledge:
  - set `err`;
  - pulse `cu_clr`;
  - go to X_WAIT.
- Events not listed for the current state are discarded and are not queued. This covers enter during a REQ state or OP_WAIT, and op keys outside OP_WAIT.

## Timing
- Reset values: state X_WAIT; `startX`/`startY`/`startS`=0; `sel`=0; `cu_clr`=0; `phase`=0; `busy`=0; `err`=0. Debounced levels and counters are 0.
- Button to event: 2 sync cycles + `DEB_CYCLES` + 1 edge-detect cycle.
- Event to request: the `start*` output rises on the clock edge after the event cycle.
- Acknowledge to release: `start*` falls on the edge after the acknowledge is sampled high. Acknowledge lasts 1 cycle minimum. Acknowledge is combinational from the control unit, so the same-cycle response is fine.
- An acknowledge arriving outside the matching REQ state is ignored.
- `sel` changes only on an op event in OP_WAIT. It is held through OP_REQ and RESULT.
- Simultaneous events:
  - clear beats enter, op and timeout;
  - an acknowledge in the same cycle as the timeout terminal count is accepted (no error).
- `rst` assertion mid-request drops all outputs immediately (asynchronously).
- Releasing `rst` does not pulse `cu_clr`. The control unit is reset by the same `rst`.
- Debounce counter: 16 bits. It saturates and does not wrap. A level change before `DEB_CYCLES` restarts it.

## Configuration
- `CALC_KEY_DEBOUNCE_EN` defined: the debounce counters are compiled in, as described above.
- Undefined: the debounce counters are removed and the synchronizer output feeds the edge detector directly. Button-to-event latency becomes 3 cycles and `DEB_CYCLES` is unused.
- The timeout, FSM and handshakes are identical in both builds.

## Test plan
- Full sequence (`DEB_CYCLES`=4 bench override):
  - stimulus: enter, ack `ldX` 2 cycles later, enter, ack `ldY`, press `btn_op`=4'b0100, ack `done`;
  - required: `startX`, then `startY`, then `startS` with `sel`=2, each high exactly until the edge after its ack; `phase` steps 0→1→2→3; `busy` high only during requests.
- Bounce: toggle `btn_enter` every 2 cycles for 20 cycles, then hold high → exactly one `startX` request.
- Op priority: `btn_op`=4'b1010 in OP_WAIT → `sel`=1.
- Timeout: hold `ldY`=0 for 255 cycles in Y_REQ → `err`=1, one `cu_clr` pulse, `phase`=0, `startY`=0. A following clear drops `err` to 0.
- Clear priority: enter and clear events in the same cycle in X_WAIT → no `startX`, one `cu_clr` pulse.
- Reset mid-OP_REQ: drive `rst`=0 asynchronously between clock edges → `startS`=0 and `sel`=0 immediately; after release, state is X_WAIT. Repeat with `CALC_KEY_DEBOUNCE_EN` undefined and check 3-cycle event latency.
